// File: rtl/sy_pkg.sv
// Shared types for the sy pipeline: RAS entry and return-address checker payloads.
package sy_pkg;

   localparam int unsigned AWTH = 32;

   typedef struct packed {
      logic            vld;
      logic [AWTH-1:0] ra;
   } ras_t;

   typedef struct packed {
      ras_t            pred;
      logic [AWTH-1:0] pc;
   } ras_chk_ent_t;

   typedef enum logic {
      RAS_CHK_NORM  = 1'b0,
      RAS_CHK_RECOV = 1'b1
   } ras_chk_st_e;

   // An invalid prediction can never be trusted, so it always counts as a miss.
   function automatic logic ras_chk_miss(input ras_t pred, input logic [AWTH-1:0] tgt);
      return (!pred.vld) || (pred.ra != tgt);
   endfunction

endpackage

// File: rtl/sy_ppl_ras_chk_fifo.sv
// Generic circular buffer with wrap-flag pointers, occupancy count and synchronous clear.
module sy_ppl_ras_chk_fifo #(
   parameter  int unsigned DEPTH = 8,
   parameter  int unsigned WIDTH = 1,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_cnt
);

   logic [PTR_W:0]   r_wr;
   logic [PTR_W:0]   r_rd;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_wr[PTR_W-1:0] == r_rd[PTR_W-1:0]) && (r_wr[PTR_W] != r_rd[PTR_W]);
   assign o_empty = (r_wr == r_rd);
   assign o_cnt   = r_wr - r_rd;
   assign o_dout  = r_mem[r_rd[PTR_W-1:0]];

   assign w_push  = i_push && !o_full && !i_clr;
   assign w_pop   = i_pop && !o_empty && !i_clr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else if (i_clr) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + (PTR_W+1)'(1);
         if (w_pop)  r_rd <= r_rd + (PTR_W+1)'(1);
      end
   end

   // Entry contents are only meaningful between the pointers, so no reset here.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr[PTR_W-1:0]] <= i_din;
   end

endmodule

// File: rtl/sy_ppl_ras_chk.sv
// Backend checker of frontend RAS return predictions; raises a registered mispredict/redirect.
// Optional hit/miss statistics counters enabled by defining SY_RAS_CHK_STAT_EN.
module sy_ppl_ras_chk
   import sy_pkg::*;
#(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            enq_vld_i,
   output logic            enq_rdy_o,
   input  ras_t            enq_pred_i,
   input  logic [AWTH-1:0] enq_pc_i,
   input  logic            res_vld_i,
   input  logic [AWTH-1:0] res_tgt_i,
   output logic            mispred_o,
   output logic [AWTH-1:0] redirect_pc_o,
   output logic [AWTH-1:0] mispred_pc_o,
   output logic            err_o,
`ifdef SY_RAS_CHK_STAT_EN
   output logic [31:0]     stat_hit_o,
   output logic [31:0]     stat_miss_o,
`endif
   output logic [PTR_W:0]  cnt_o
);

   localparam int unsigned EWTH = $bits(ras_chk_ent_t);

   ras_chk_st_e     r_state;
   ras_chk_st_e     w_state_nxt;
   ras_chk_ent_t    w_head;
   logic [EWTH-1:0] w_head_raw;
   logic            w_full;
   logic            w_empty;
   logic            w_enq_fire;
   logic            w_res_fire;
   logic            w_mis;
   logic            w_err;
   logic            w_clr;
   logic            r_mispred;
   logic            r_err;
   logic [AWTH-1:0] r_redirect_pc;
   logic [AWTH-1:0] r_mispred_pc;

   assign w_head = ras_chk_ent_t'(w_head_raw);

   sy_ppl_ras_chk_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EWTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_clr   (w_clr),
      .i_push  (w_enq_fire),
      .i_din   (EWTH'({enq_pred_i, enq_pc_i})),
      .i_pop   (w_res_fire),
      .o_dout  (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_cnt   (cnt_o)
   );

   assign enq_rdy_o = !w_full && (r_state == RAS_CHK_NORM);

   // Flush dominates everything; a mismatch wipes the wrong-path entries and drops any enqueue.
   always_comb begin
      w_state_nxt = r_state;
      w_res_fire  = 1'b0;
      w_err       = 1'b0;
      w_mis       = 1'b0;
      w_enq_fire  = 1'b0;
      if (!flush_i && (r_state == RAS_CHK_NORM)) begin
         w_res_fire = res_vld_i && !w_empty;
         w_err      = res_vld_i && w_empty;
         w_mis      = w_res_fire && ras_chk_miss(w_head.pred, res_tgt_i);
         w_enq_fire = enq_vld_i && enq_rdy_o && !w_mis;
      end
      if (flush_i)    w_state_nxt = RAS_CHK_NORM;
      else if (w_mis) w_state_nxt = RAS_CHK_RECOV;
   end

   assign w_clr = flush_i || w_mis;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state       <= RAS_CHK_NORM;
         r_mispred     <= 1'b0;
         r_err         <= 1'b0;
         r_redirect_pc <= '0;
         r_mispred_pc  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_mispred <= w_mis;
         r_err     <= w_err;
         if (w_mis) begin
            r_redirect_pc <= res_tgt_i;
            r_mispred_pc  <= w_head.pc;
         end
      end
   end

   assign mispred_o     = r_mispred;
   assign err_o         = r_err;
   assign redirect_pc_o = r_redirect_pc;
   assign mispred_pc_o  = r_mispred_pc;

`ifdef SY_RAS_CHK_STAT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   // Saturating counters survive flush; only reset clears them.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (w_res_fire) begin
         if (w_mis) begin
            if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
         end else begin
            if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
         end
      end
   end

   assign stat_hit_o  = r_hit_cnt;
   assign stat_miss_o = r_miss_cnt;
`endif

endmodule

// File: doc/sy_ppl_ras_chk.md
Name: sy_ppl_ras_chk

Overview:
- Backend-side checker for return-address predictions made by the frontend RAS.
- Frontend writes one entry per predicted return (the RAS top, a ras_t); execute resolves returns in program order.
- The block compares the actual target against the queued prediction and raises a registered mispredict/redirect.
- It sits between the frontend branch-prediction stage and the execute/redirect logic.

Parameters:
DEPTH, 8, number of outstanding unresolved returns (power of 2, >=2)
PTR_W, $clog2(DEPTH), index width (derived; not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
flush_i  in  1  pipeline flush; clears queue, returns FSM to NORM
enq_vld_i  in  1  frontend presents a predicted return
enq_rdy_o  out  1  queue can accept (!full and state==NORM)
enq_pred_i  in  ras_t  predicted return address plus valid bit from RAS top
enq_pc_i  in  AWTH  PC of the return instruction
res_vld_i  in  1  execute resolves the oldest outstanding return
res_tgt_i  in  AWTH  actual return target
mispred_o  out  1  one-cycle pulse, registered
redirect_pc_o  out  AWTH  correct target, valid with mispred_o
mispred_pc_o  out  AWTH  PC of the mispredicted return, valid with mispred_o
err_o  out  1  one-cycle pulse: resolve received with empty queue
cnt_o  out  PTR_W+1  current occupancy

Behaviour:
- Reset: queue empty, rd/wr pointers 0, state NORM, all outputs 0 except enq_rdy_o=1.
- Storage is a circular buffer with rd/wr pointers of PTR_W+1 bits; the extra bit is the wrap flag.
  - full: indices equal and wrap bits differ.
  - empty: pointers equal.
  - cnt_o = wr - rd, modulo 2^(PTR_W+1).
- Enqueue: fires on enq_vld_i & enq_rdy_o; stores {pred, pc} at wr and increments wr. Ready is based on the registered state only; a same-cycle dequeue does not make a full queue ready.
- Resolve: fires on res_vld_i while state==NORM and the queue is non-empty.
  - Reads the head entry and increments rd.
  - Mismatch when !pred.vld or pred.ra != res_tgt_i.
- Resolve with empty queue: no pop. err_o pulses next cycle. No bypass, even if an enqueue occurs in the same cycle.
- Mismatch, registered (1-cycle latency):
  - Next cycle: mispred_o=1, redirect_pc_o=res_tgt_i, mispred_pc_o=head.pc.
  - Queue cleared at that same clock edge; all younger entries are wrong-path.
  - Any same-cycle enqueue is dropped.
  - FSM goes NORM->RECOV.
- Match: pop only; no output.
- FSM, 2 states:
  - NORM: normal operation.
  - RECOV: enq_rdy_o=0, res_vld_i ignored with no err_o; exits to NORM only on flush_i. The redirect path always produces a flush.
- flush_i has highest priority:
  - Clears pointers; state goes to NORM.
  - Same-cycle enqueue and resolve are discarded.
  - mispred_o/err_o for that cycle's resolve are suppressed.
  - A mispred pulse already registered on the flush cycle still appears.
- Reset asserted mid-operation: immediate asynchronous clear to reset values.
- Wrap-around: pointers wrap naturally after 2*DEPTH operations; no special case.
- Storage entries need no reset; validity is implied by the pointers.

Optional Feature:
- Macro: SY_RAS_CHK_STAT_EN.
- When defined:
  - Adds two 32-bit saturating counters, hit_cnt and miss_cnt.
  - Each resolve increments exactly one of them; saturate at 0xFFFF_FFFF.
  - Cleared by reset only, not by flush.
  - Exposed on extra outputs stat_hit_o / stat_miss_o, 32 bits each.
- When not defined: ports and logic are absent.

Decomposition:
- sy_pkg holds:
  - ras_t (reuse existing).
  - New ras_chk_ent_t {ras_t pred; logic [AWTH-1:0] pc;}.
  - ras_chk_st_e {RAS_CHK_NORM, RAS_CHK_RECOV}.
- One natural sub-module: sy_ppl_ras_chk_fifo, a generic circular buffer with full/empty/count and synchronous clear. Compare logic and the FSM stay in the top.

Test Plan:
- Enqueue pred {vld=1, ra=0x8000_1000}, then resolve tgt 0x8000_1000 -> no mispred_o, cnt_o 1->0, hit_cnt=1 (with STAT_EN).
- Enqueue {1,0x100}, {1,0x200}, {1,0x300}; resolve 0x100 then 0x250 -> second resolve gives mispred_o next cycle, redirect_pc_o=0x250, cnt_o=0, enq_rdy_o=0 until flush_i, then 1.
- Enqueue pred vld=0, ra=0; resolve tgt 0x0 -> mispred_o (invalid prediction is always a miss), redirect_pc_o=0x0.
- Fill DEPTH=8 entries -> enq_rdy_o=0, cnt_o=8. Enqueue+resolve (hit) in the same cycle -> enqueue not accepted, cnt_o=7. Run 20 mixed ops -> pointer wrap, order preserved.
- Resolve on empty queue -> err_o pulse next cycle, cnt_o stays 0. Same resolve in RECOV -> no err_o.
- Flush_i with a concurrent mismatching resolve and an enqueue (3 entries queued) -> no mispred_o, cnt_o=0, state NORM, enq_rdy_o=1. Reset asserted mid-fill -> immediate empty, outputs at reset values.
